// File: rtl/hazard_ctrl_unit.sv
// Stall/flush controller with a 2-bit branch predictor for an in-order pipeline.
// Define HAZARD_CTRL_PERF_EN to add stall/flush/mispredict performance counters.
module hazard_ctrl_unit #(
  parameter int NSTAGE    = 5,
  parameter int PHT_DEPTH = 16,
  parameter int LOAD_LAT  = 1,
  parameter int RW        = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              me_req,
  input  logic [RW-1:0]     id_rs,
  input  logic [RW-1:0]     id_rt,
  input  logic              ex_ren,
  input  logic [RW-1:0]     ex_rdst,
  input  logic              br_id_valid,
  input  logic [31:0]       br_id_pc,
  input  logic              br_ex_valid,
  input  logic [31:0]       br_ex_pc,
  input  logic              br_ex_taken,
  input  logic              br_ex_pred,
  output logic [NSTAGE-1:0] en,
  output logic [NSTAGE-1:0] flush,
  output logic              pred_taken,
  output logic [1:0]        PCSel,
  output logic              mispredict
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       mispred_cnt
`endif
);

  localparam int IW = $clog2(PHT_DEPTH);
  localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_LDSTALL,
    S_RECOVER
  } state_t;

  state_t      r_state;
  logic [2:0]  r_ld_cnt;
  logic        r_first;
  logic [1:0]  r_pht [PHT_DEPTH];

  logic          w_frz;
  logic          w_mp;
  logic          w_lu;
  logic [IW-1:0] w_idx_id;
  logic [IW-1:0] w_idx_ex;
  logic [1:0]    w_ctr;

  assign w_frz    = me_req & ~dhit;
  assign w_mp     = br_ex_valid & (br_ex_taken != br_ex_pred)
                  & (r_state != S_RECOVER);
  assign w_lu     = ex_ren & (ex_rdst != '0)
                  & ((ex_rdst == id_rs) | (ex_rdst == id_rt));
  assign w_idx_id = br_id_pc[IW+1:2];
  assign w_idx_ex = br_ex_pc[IW+1:2];
  assign w_ctr    = r_pht[w_idx_ex];

  always_comb begin
    en         = '1;
    flush      = '0;
    PCSel      = 2'b00;
    mispredict = 1'b0;
    pred_taken = 1'b0;
    if (RST || r_first) begin
      en    = '0;
      flush = '1;
    end else begin
      pred_taken = br_id_valid & r_pht[w_idx_id][1];
      if (w_frz) begin
        en = '0;
        if (r_state == S_RECOVER) PCSel = 2'b10;
      end else if (w_mp) begin
        mispredict = 1'b1;
        en[0]      = ihit;
        flush[2:1] = 2'b11;
        PCSel      = 2'b10;
      end else if (r_state == S_RECOVER) begin
        en[1:0]    = {1'b0, ihit};
        flush[2:1] = 2'b11;
        PCSel      = 2'b10;
      end else if (r_state == S_LDSTALL || w_lu || !ihit) begin
        en[1:0]  = 2'b00;
        flush[2] = 1'b1;
      end else if (pred_taken) begin
        PCSel = 2'b01;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_RUN;
      r_ld_cnt <= '0;
      r_first  <= 1'b1;
      for (int i = 0; i < PHT_DEPTH; i++) r_pht[i] <= 2'b01;
    end else begin
      r_first <= 1'b0;
      // en[3] is low while frozen or in the post-reset cycle
      if (br_ex_valid && en[3]) begin
        if (br_ex_taken && w_ctr != 2'b11)
          r_pht[w_idx_ex] <= w_ctr + 2'b01;
        else if (!br_ex_taken && w_ctr != 2'b00)
          r_pht[w_idx_ex] <= w_ctr - 2'b01;
      end
      if (!r_first && !w_frz) begin
        unique case (r_state)
          S_RUN: begin
            if (w_mp) begin
              r_state <= ihit ? S_RUN : S_RECOVER;
            end else if (w_lu && LOAD_LAT > 1) begin
              r_state  <= S_LDSTALL;
              r_ld_cnt <= LD_INIT;
            end
          end
          S_LDSTALL: begin
            if (w_mp) begin
              r_state  <= ihit ? S_RUN : S_RECOVER;
              r_ld_cnt <= '0;
            end else begin
              r_ld_cnt <= r_ld_cnt - 3'd1;
              if (r_ld_cnt == 3'd1) r_state <= S_RUN;
            end
          end
          S_RECOVER: if (ihit) r_state <= S_RUN;
          default:   r_state <= S_RUN;
        endcase
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mispred_cnt <= '0;
    end else if (!r_first) begin
      stall_cnt   <= stall_cnt + 32'(!en[0]);
      flush_cnt   <= flush_cnt + 32'(|flush);
      mispred_cnt <= mispred_cnt + 32'(mispredict);
    end
  end
`endif

endmodule
